// File: rtl/irrigation_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// irrigation_pkg
// Shared types and constants for the irrigation phase sequencer:
//   state_t        : scheduler state encoding (codes 6/7 unused)
//   DEF_T_*        : default phase durations in ticks
//   phase_duration : counter load value for a given state
// ---------------------------------------------------------------------------
package irrigation_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SPRINKLE = 3'd1,
      ST_DRIP     = 3'd2,
      ST_DRIP_EXT = 3'd3,
      ST_CLEAN    = 3'd4,
      ST_FILL     = 3'd5
   } state_t;

   localparam int unsigned DEF_CNT_W      = 8;
   localparam int unsigned DEF_T_SPRINKLE = 30;
   localparam int unsigned DEF_T_DRIP     = 60;
   localparam int unsigned DEF_T_EXT      = 15;
   localparam int unsigned DEF_T_CLEAN    = 10;
   localparam int unsigned DEF_T_FILL_MAX = 120;

   // Duration loaded on entry to a state; IDLE (and anything else) loads 0.
   function automatic int unsigned phase_duration(
      input state_t      s,
      input int unsigned t_sprinkle,
      input int unsigned t_drip,
      input int unsigned t_ext,
      input int unsigned t_clean,
      input int unsigned t_fill_max
   );
      case (s)
         ST_SPRINKLE: phase_duration = t_sprinkle;
         ST_DRIP:     phase_duration = t_drip;
         ST_DRIP_EXT: phase_duration = t_ext;
         ST_CLEAN:    phase_duration = t_clean;
         ST_FILL:     phase_duration = t_fill_max;
         default:     phase_duration = 0;
      endcase
   endfunction

endpackage

// File: rtl/irrigation_scheduler_if.sv
// ---------------------------------------------------------------------------
// irrigation_scheduler_if
// Sensor/button inputs and actuator/status outputs of the scheduler.
//   master : front end side (drives tick/start/abort/sensors, reads status)
//   slave  : scheduler side (reads inputs, drives valves/pump/status)
// ---------------------------------------------------------------------------
interface irrigation_scheduler_if #(
   parameter int unsigned CNT_W = 8
);
   logic             tick;
   logic             start;
   logic             abort;
   logic             hum_low;
   logic             temp_high;
   logic             level_full;
   logic             valve_sprinkle;
   logic             valve_drip;
   logic             valve_clean;
   logic             pump_fill;
   logic [2:0]       state;
   logic [CNT_W-1:0] remaining;
   logic             cycle_done;
   logic             fill_timeout;

   modport master (
      output tick, start, abort, hum_low, temp_high, level_full,
      input  valve_sprinkle, valve_drip, valve_clean, pump_fill,
             state, remaining, cycle_done, fill_timeout
   );

   modport slave (
      input  tick, start, abort, hum_low, temp_high, level_full,
      output valve_sprinkle, valve_drip, valve_clean, pump_fill,
             state, remaining, cycle_done, fill_timeout
   );
endinterface

// File: rtl/irrigation_scheduler_phase_counter.sv
// ---------------------------------------------------------------------------
// phase_counter
// Down-counter timing one scheduler phase.
//   clk, reset_n : clock, synchronous active-low reset
//   i_load       : load i_load_val (takes precedence over tick)
//   i_load_val   : phase duration in ticks
//   i_tick       : time-base enable; decrements while nonzero
//   i_clear      : force the count to 0
//   o_remaining  : ticks left in the phase
//   o_expire     : last tick of the phase (tick while remaining == 1)
// ---------------------------------------------------------------------------
module phase_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_tick,
   input  logic             i_clear,
   output logic [CNT_W-1:0] o_remaining,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_remaining;

   always_ff @(posedge clk) begin
      if (!reset_n || i_clear) begin
         r_remaining <= '0;
      end else if (i_load) begin
         r_remaining <= i_load_val;
      end else if (i_tick && (r_remaining != '0)) begin
         r_remaining <= r_remaining - CNT_W'(1);
      end
   end

   assign o_remaining = r_remaining;
   assign o_expire    = i_tick && (r_remaining == CNT_W'(1));

endmodule

// File: rtl/irrigation_scheduler.sv
// ---------------------------------------------------------------------------
// irrigation_scheduler
// Phase sequencer: IDLE -> SPRINKLE|DRIP[->DRIP_EXT] -> CLEAN -> FILL -> IDLE.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : tick/start/abort/hum_low/temp_high/level_full in;
//                  valve_sprinkle/valve_drip/valve_clean/pump_fill,
//                  state, remaining, cycle_done, fill_timeout out
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module irrigation_scheduler
   import irrigation_pkg::*;
#(
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned T_SPRINKLE = DEF_T_SPRINKLE,
   parameter int unsigned T_DRIP     = DEF_T_DRIP,
   parameter int unsigned T_EXT      = DEF_T_EXT,
   parameter int unsigned T_CLEAN    = DEF_T_CLEAN,
   parameter int unsigned T_FILL_MAX = DEF_T_FILL_MAX
) (
   input logic                  clk,
   input logic                  reset_n,
   irrigation_scheduler_if.slave bus
);

   state_t           r_state;
   logic             r_valve_sprinkle;
   logic             r_valve_drip;
   logic             r_valve_clean;
   logic             r_pump_fill;
   logic             r_cycle_done;
   logic             r_fill_timeout;

   state_t           w_next;
   logic             w_load;
   logic             w_clear;
   logic             w_done;
   logic             w_fto_set;
   logic             w_fto_clr;
   logic             w_expire;
   logic [CNT_W-1:0] w_remaining;
   logic [CNT_W-1:0] w_load_val;

   // Next-state decision; priority abort > level_full > expiry > start.
   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_clear   = 1'b0;
      w_done    = 1'b0;
      w_fto_set = 1'b0;
      w_fto_clr = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start && bus.hum_low) begin
               w_next    = bus.temp_high ? ST_SPRINKLE : ST_DRIP;
               w_load    = 1'b1;
               w_fto_clr = 1'b1;
            end
         end
         ST_SPRINKLE: begin
            if (bus.abort) begin
               w_next  = ST_IDLE;
               w_clear = 1'b1;
            end else if (w_expire) begin
               w_next = ST_CLEAN;
               w_load = 1'b1;
            end
         end
         ST_DRIP: begin
            if (bus.abort) begin
               w_next  = ST_IDLE;
               w_clear = 1'b1;
            end else if (w_expire) begin
               // Soil still dry and not hot: extend drip instead of flushing.
               w_next = (bus.hum_low && !bus.temp_high) ? ST_DRIP_EXT : ST_CLEAN;
               w_load = 1'b1;
            end
         end
         ST_DRIP_EXT: begin
            if (bus.abort) begin
               w_next  = ST_IDLE;
               w_clear = 1'b1;
            end else if (w_expire) begin
               w_next = ST_CLEAN;
               w_load = 1'b1;
            end
         end
         ST_CLEAN: begin
            if (bus.abort) begin
               w_next  = ST_IDLE;
               w_clear = 1'b1;
            end else if (w_expire) begin
               w_next = ST_FILL;
               w_load = 1'b1;
            end
         end
         ST_FILL: begin
            if (bus.abort) begin
               w_next  = ST_IDLE;
               w_clear = 1'b1;
            end else if (bus.level_full) begin
               w_next  = ST_IDLE;
               w_clear = 1'b1;
               w_done  = 1'b1;
            end else if (w_expire) begin
               w_next    = ST_IDLE;
               w_clear   = 1'b1;
               w_done    = 1'b1;
               w_fto_set = 1'b1;
            end
         end
         default: begin
            w_next  = ST_IDLE;
            w_clear = 1'b1;
         end
      endcase
      w_load_val = CNT_W'(phase_duration(w_next, T_SPRINKLE, T_DRIP, T_EXT,
                                         T_CLEAN, T_FILL_MAX));
   end

   // Actuators are registered from the next state, so they always match
   // the decode of r_state without any input-to-output path.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state          <= ST_IDLE;
         r_valve_sprinkle <= 1'b0;
         r_valve_drip     <= 1'b0;
         r_valve_clean    <= 1'b0;
         r_pump_fill      <= 1'b0;
         r_cycle_done     <= 1'b0;
         r_fill_timeout   <= 1'b0;
      end else begin
         r_state          <= w_next;
         r_valve_sprinkle <= (w_next == ST_SPRINKLE);
         r_valve_drip     <= (w_next == ST_DRIP) || (w_next == ST_DRIP_EXT);
         r_valve_clean    <= (w_next == ST_CLEAN);
         r_pump_fill      <= (w_next == ST_FILL);
         r_cycle_done     <= w_done;
         if (w_fto_clr) begin
            r_fill_timeout <= 1'b0;
         end else if (w_fto_set) begin
            r_fill_timeout <= 1'b1;
         end
      end
   end

   phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase_counter (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_load      (w_load),
      .i_load_val  (w_load_val),
      .i_tick      (bus.tick),
      .i_clear     (w_clear),
      .o_remaining (w_remaining),
      .o_expire    (w_expire)
   );

   assign bus.state          = r_state;
   assign bus.remaining      = w_remaining;
   assign bus.valve_sprinkle = r_valve_sprinkle;
   assign bus.valve_drip     = r_valve_drip;
   assign bus.valve_clean    = r_valve_clean;
   assign bus.pump_fill      = r_pump_fill;
   assign bus.cycle_done     = r_cycle_done;
   assign bus.fill_timeout   = r_fill_timeout;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// ---------------------------------------------------------------------------
// tb_irrigation_scheduler
// Self-checking bench for irrigation_scheduler with short phase durations.
// ---------------------------------------------------------------------------
module tb_irrigation_scheduler;

   localparam int unsigned CNT_W  = 8;
   localparam int          T_SP   = 3;
   localparam int          T_DR   = 4;
   localparam int          T_EX   = 2;
   localparam int          T_CL   = 2;
   localparam int          T_FILL = 5;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   irrigation_scheduler_if #(.CNT_W(CNT_W)) bus ();

   irrigation_scheduler #(
      .CNT_W      (CNT_W),
      .T_SPRINKLE (T_SP),
      .T_DRIP     (T_DR),
      .T_EXT      (T_EX),
      .T_CLEAN    (T_CL),
      .T_FILL_MAX (T_FILL)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] rem;
      logic       vs;
      logic       vd;
      logic       vc;
      logic       pf;
      logic       done;
      logic       fto;
   } outs_t;

   typedef struct {
      logic  rst_n;
      logic  start;
      logic  abort;
      logic  hum;
      logic  temp;
      logic  lf;
      outs_t exp;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: phase number, ticks left, flags.
   int m_ph  = 0;
   int m_rem = 0;
   bit m_done = 0;
   bit m_fto  = 0;

   function automatic int dur(input int p);
      case (p)
         1: return T_SP;
         2: return T_DR;
         3: return T_EX;
         4: return T_CL;
         5: return T_FILL;
         default: return 0;
      endcase
   endfunction

   task automatic m_enter(input int p);
      m_ph  = p;
      m_rem = dur(p);
   endtask

   task automatic m_step();
      m_done = 0;
      if (!reset_n) begin
         m_ph = 0; m_rem = 0; m_fto = 0;
      end else if (m_ph == 0) begin
         if (bus.start && bus.hum_low) begin
            m_fto = 0;
            m_enter(bus.temp_high ? 1 : 2);
         end
      end else if (bus.abort) begin
         m_ph = 0; m_rem = 0;
      end else if (m_ph == 5 && bus.level_full) begin
         m_ph = 0; m_rem = 0; m_done = 1;
      end else begin
         if (bus.tick) m_rem = m_rem - 1;
         if (m_rem == 0) begin
            case (m_ph)
               1: m_enter(4);
               2: m_enter((bus.hum_low && !bus.temp_high) ? 3 : 4);
               3: m_enter(4);
               4: m_enter(5);
               default: begin m_ph = 0; m_done = 1; m_fto = 1; end
            endcase
         end
      end
   endtask

   function automatic outs_t mk(input int st, input int rem, input bit vs, input bit vd,
                                input bit vc, input bit pf, input bit done, input bit fto);
      outs_t o;
      o.st = 3'(st); o.rem = 8'(rem);
      o.vs = vs; o.vd = vd; o.vc = vc; o.pf = pf; o.done = done; o.fto = fto;
      return o;
   endfunction

   function automatic outs_t model_outs();
      return mk(m_ph, m_rem, m_ph == 1, (m_ph == 2) || (m_ph == 3), m_ph == 4, m_ph == 5,
                m_done, m_fto);
   endfunction

   function automatic outs_t dut_outs();
      outs_t o;
      o.st = bus.state; o.rem = bus.remaining;
      o.vs = bus.valve_sprinkle; o.vd = bus.valve_drip; o.vc = bus.valve_clean;
      o.pf = bus.pump_fill; o.done = bus.cycle_done; o.fto = bus.fill_timeout;
      return o;
   endfunction

   task automatic check(input string name, input outs_t act, input outs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: actual st=%0d rem=%0d vs/vd/vc/pf=%b%b%b%b done=%b fto=%b, expected st=%0d rem=%0d vs/vd/vc/pf=%b%b%b%b done=%b fto=%b",
                  name, $time, act.st, act.rem, act.vs, act.vd, act.vc, act.pf, act.done, act.fto,
                  exp.st, exp.rem, exp.vs, exp.vd, exp.vc, exp.pf, exp.done, exp.fto);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: edge, advance model, compare shortly after the edge.
   task automatic step(input string name);
      @(posedge clk);
      m_step();
      #1;
      check(name, dut_outs(), model_outs());
   endtask

   task automatic set_in(input logic rn, input logic st, input logic ab, input logic hum,
                         input logic tmp, input logic lf);
      reset_n = rn; bus.start = st; bus.abort = ab;
      bus.hum_low = hum; bus.temp_high = tmp; bus.level_full = lf;
   endtask

   vec_t tbl[11];

   initial begin
      int nd, nc, np, ndone;
      bus.tick = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);

      // Sprinkler cycle, expected values derived by hand.
      tbl[0]  = '{0, 0, 0, 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[1]  = '{1, 1, 0, 1, 1, 0, mk(1, 3, 1, 0, 0, 0, 0, 0)};
      tbl[2]  = '{1, 0, 0, 1, 1, 0, mk(1, 2, 1, 0, 0, 0, 0, 0)};
      tbl[3]  = '{1, 0, 0, 1, 1, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
      tbl[4]  = '{1, 0, 0, 1, 1, 0, mk(4, 2, 0, 0, 1, 0, 0, 0)};
      tbl[5]  = '{1, 0, 0, 1, 1, 0, mk(4, 1, 0, 0, 1, 0, 0, 0)};
      tbl[6]  = '{1, 0, 0, 1, 1, 0, mk(5, 5, 0, 0, 0, 1, 0, 0)};
      tbl[7]  = '{1, 0, 0, 1, 1, 0, mk(5, 4, 0, 0, 0, 1, 0, 0)};
      tbl[8]  = '{1, 0, 0, 1, 1, 0, mk(5, 3, 0, 0, 0, 1, 0, 0)};
      tbl[9]  = '{1, 0, 0, 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 0)};
      tbl[10] = '{1, 0, 0, 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};

      for (int i = 0; i < 11; i++) begin
         set_in(tbl[i].rst_n, tbl[i].start, tbl[i].abort, tbl[i].hum, tbl[i].temp, tbl[i].lf);
         @(posedge clk);
         m_step();
         #1;
         check($sformatf("tbl[%0d]", i), dut_outs(), tbl[i].exp);
      end

      // Drip with extension: 6 drip cycles, then 2 clean cycles.
      nd = 0; nc = 0;
      set_in(1, 1, 0, 1, 0, 0);
      step("drip_ext_start");
      if (bus.valve_drip) nd++;
      bus.start = 0;
      for (int i = 0; i < 11; i++) begin
         step("drip_ext");
         if (bus.valve_drip) nd++;
         if (bus.valve_clean) nc++;
      end
      check_val("drip_ext_len", nd, 6);
      check_val("drip_ext_clean_len", nc, 2);
      bus.level_full = 1;
      step("drip_ext_full");
      bus.level_full = 0;

      // Drip without extension, then fill watchdog.
      nd = 0; nc = 0; np = 0; ndone = 0;
      set_in(1, 1, 0, 1, 0, 0);
      step("drip_noext_start");
      if (bus.valve_drip) nd++;
      bus.start = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 1) bus.temp_high = 1;
         step("drip_noext");
         if (bus.valve_drip) nd++;
         if (bus.valve_clean) nc++;
         if (bus.pump_fill) np++;
         if (bus.cycle_done) ndone++;
      end
      check_val("drip_noext_len", nd, 4);
      check_val("drip_noext_clean_len", nc, 2);
      check_val("fill_watchdog_len", np, 5);
      check_val("fill_watchdog_done", ndone, 1);
      check_val("fill_timeout_set", int'(bus.fill_timeout), 1);

      // Accepted start clears the timeout flag; then abort in 2nd SPRINKLE cycle.
      set_in(1, 1, 0, 1, 1, 0);
      step("restart");
      check_val("fill_timeout_cleared", int'(bus.fill_timeout), 0);
      bus.start = 0;
      step("sprinkle2");
      bus.abort = 1;
      step("abort");
      check("abort_outs", dut_outs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
      bus.abort = 0;

      // Start ignored with dry-soil flag low.
      set_in(1, 1, 0, 0, 1, 0);
      step("start_hum0");
      check_val("start_hum0_state", int'(bus.state), 0);

      // Reset in the middle of CLEAN.
      set_in(1, 1, 0, 1, 1, 0);
      step("rst_run");
      bus.start = 0;
      for (int i = 0; i < 3; i++) step("rst_run");
      check_val("rst_in_clean", int'(bus.valve_clean), 1);
      reset_n = 0;
      step("rst_mid_clean");
      check("rst_outs", dut_outs(), mk(0, 0, 0, 0, 0, 0, 0, 0));
      reset_n = 1;

      // Start during DRIP does not disturb the count.
      set_in(1, 1, 0, 1, 0, 0);
      step("drip_start");
      bus.start = 0;
      step("drip_run");
      bus.start = 1;
      step("drip_start_ignored");
      check("drip_start_outs", dut_outs(), mk(2, 2, 0, 1, 0, 0, 0, 0));
      set_in(1, 0, 1, 1, 0, 0);
      step("drip_abort");

      // Randomized traffic against the model, including tick gaps.
      for (int i = 0; i < 3000; i++) begin
         reset_n        = ($urandom_range(0, 99) != 0);
         bus.start      = ($urandom_range(0, 3) == 0);
         bus.abort      = ($urandom_range(0, 39) == 0);
         bus.hum_low    = ($urandom_range(0, 3) != 0);
         bus.temp_high  = 1'($urandom_range(0, 1));
         bus.level_full = ($urandom_range(0, 5) == 0);
         bus.tick       = ($urandom_range(0, 2) != 0);
         step("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
